// File: rtl/fei4_cmd_decoder.sv
// fei4_cmd_decoder: deserializes the FE-I4 serial command stream into trigger/fast strobes and slow-command fields.
// Latency: every strobe asserts one cycle after the edge that samples the command's last bit.
// Backpressure: none; one bit is consumed per CMD_CLK and back-to-back commands need no gap.
module fei4_cmd_decoder #(
  parameter int         FE_BITS     = 672,
  parameter logic [5:0] RUNMODE_ON  = 6'b111000,
  parameter logic [5:0] RUNMODE_OFF = 6'b000111
) (
  input  logic        CMD_CLK,
  input  logic        RESET,
  input  logic        CMD_DATA,
  input  logic [2:0]  CHIP_ID,
  output logic        LV1,
  output logic        BCR,
  output logic        ECR,
  output logic        CAL,
  output logic        SLOW_VALID,
  output logic [3:0]  SLOW_CMD,
  output logic [5:0]  SLOW_ADDR,
  output logic [15:0] SLOW_DATA,
  output logic        FE_BIT,
  output logic        FE_BIT_VALID,
  output logic        RUN_MODE,
  output logic        BUSY,
  output logic        ERR
);

  localparam logic [4:0] HDR_LV1    = 5'b11101;
  localparam logic [4:0] HDR_CMD    = 5'b10110;
  localparam logic [3:0] F2_BCR     = 4'b0001;
  localparam logic [3:0] F2_ECR     = 4'b0010;
  localparam logic [3:0] F2_CAL     = 4'b0100;
  localparam logic [3:0] F2_SLOW    = 4'b1000;
  localparam logic [3:0] SC_RDREG   = 4'b0001;
  localparam logic [3:0] SC_WRREG   = 4'b0010;
  localparam logic [3:0] SC_WRFE    = 4'b0100;
  localparam logic [3:0] SC_GRST    = 4'b1000;
  localparam logic [3:0] SC_GPULSE  = 4'b1001;
  localparam logic [3:0] SC_RUNMODE = 4'b1010;
  // Last payload index of a WrFE; the counter is 10 bits so FE_BITS must stay <= 1024.
  localparam logic [9:0] FE_LAST    = 10'(FE_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_FIELD2,
    S_SLOW,
    S_DATA16,
    S_FEDATA
  } state_t;

  state_t      state;
  logic [14:0] sr;        // previously sampled bits, newest in bit 0
  logic [4:0]  cnt;       // bits collected in the current field group
  logic [9:0]  fe_cnt;    // WrFE payload bits consumed so far
  logic [3:0]  cmd_q;     // field3 held while DATA16/FEDATA run
  logic [5:0]  addr_q;    // field5 held while DATA16/FEDATA run
  logic        match_q;   // slow command addressed to this chip

  logic [15:0] shifted;
  logic [4:0]  hdr_now;
  logic [3:0]  f2_now;
  logic [3:0]  f3_now;
  logic [3:0]  f4_now;
  logic [5:0]  f5_now;
  logic        match_now;
  logic        known_now;

  // Field views of the history with the bit being sampled this edge appended.
  always_comb begin
    shifted   = {sr, CMD_DATA};
    hdr_now   = shifted[4:0];
    f2_now    = shifted[3:0];
    f3_now    = shifted[13:10];
    f4_now    = shifted[9:6];
    f5_now    = shifted[5:0];
    match_now = f4_now[3] || (f4_now[2:0] == CHIP_ID);
    known_now = 1'b0;
    case (f3_now)
      SC_RDREG, SC_WRREG, SC_WRFE, SC_GRST, SC_GPULSE, SC_RUNMODE: known_now = 1'b1;
      default: known_now = 1'b0;
    endcase
  end

  assign BUSY = (state != S_IDLE);

  // Command FSM: shifts one bit per clock, emits registered strobes and latches slow fields on completion.
  always_ff @(posedge CMD_CLK) begin
    if (RESET) begin
      state        <= S_IDLE;
      sr           <= '0;
      cnt          <= '0;
      fe_cnt       <= '0;
      cmd_q        <= '0;
      addr_q       <= '0;
      match_q      <= 1'b0;
      LV1          <= 1'b0;
      BCR          <= 1'b0;
      ECR          <= 1'b0;
      CAL          <= 1'b0;
      SLOW_VALID   <= 1'b0;
      SLOW_CMD     <= '0;
      SLOW_ADDR    <= '0;
      SLOW_DATA    <= '0;
      FE_BIT       <= 1'b0;
      FE_BIT_VALID <= 1'b0;
      RUN_MODE     <= 1'b0;
      ERR          <= 1'b0;
    end else begin
      LV1          <= 1'b0;
      BCR          <= 1'b0;
      ECR          <= 1'b0;
      CAL          <= 1'b0;
      SLOW_VALID   <= 1'b0;
      FE_BIT       <= 1'b0;
      FE_BIT_VALID <= 1'b0;
      ERR          <= 1'b0;
      sr           <= shifted[14:0];
      cnt          <= cnt + 5'd1;

      case (state)
        S_IDLE: begin
          // Every command starts with a 1; leading zeros are idle filler.
          cnt <= 5'd1;
          if (CMD_DATA) begin
            state <= S_HDR;
          end
        end

        S_HDR: begin
          if (cnt == 5'd4) begin
            cnt <= '0;
            if (hdr_now == HDR_LV1) begin
              LV1   <= 1'b1;
              state <= S_IDLE;
            end else if (hdr_now == HDR_CMD) begin
              state <= S_FIELD2;
            end else begin
              ERR   <= 1'b1;
              state <= S_IDLE;
            end
          end
        end

        S_FIELD2: begin
          if (cnt == 5'd3) begin
            cnt   <= '0;
            state <= S_IDLE;
            case (f2_now)
              F2_BCR:  BCR <= 1'b1;
              F2_ECR:  ECR <= 1'b1;
              F2_CAL:  CAL <= 1'b1;
              F2_SLOW: state <= S_SLOW;
              default: ERR <= 1'b1;
            endcase
          end
        end

        S_SLOW: begin
          // field3/field4/field5 arrive as one 14-bit group.
          if (cnt == 5'd13) begin
            cnt     <= '0;
            cmd_q   <= f3_now;
            addr_q  <= f5_now;
            match_q <= match_now;
            if (f3_now == SC_WRREG) begin
              state <= S_DATA16;
            end else if (f3_now == SC_WRFE) begin
              fe_cnt <= '0;
              state  <= S_FEDATA;
            end else begin
              state <= S_IDLE;
              // An unknown opcode is a stream error whoever it is addressed to.
              if (!known_now) begin
                ERR <= 1'b1;
              end else if (match_now) begin
                SLOW_VALID <= 1'b1;
                SLOW_CMD   <= f3_now;
                SLOW_ADDR  <= f5_now;
                SLOW_DATA  <= '0;
                if (f3_now == SC_RUNMODE) begin
                  if (f5_now == RUNMODE_ON) begin
                    RUN_MODE <= 1'b1;
                  end else if (f5_now == RUNMODE_OFF) begin
                    RUN_MODE <= 1'b0;
                  end
                end
              end
            end
          end
        end

        S_DATA16: begin
          if (cnt == 5'd15) begin
            cnt   <= '0;
            state <= S_IDLE;
            if (match_q) begin
              SLOW_VALID <= 1'b1;
              SLOW_CMD   <= cmd_q;
              SLOW_ADDR  <= addr_q;
              SLOW_DATA  <= shifted;
            end
          end
        end

        S_FEDATA: begin
          // Payload bits are forwarded one cycle after sampling; unaddressed payload is swallowed.
          fe_cnt <= fe_cnt + 10'd1;
          if (match_q) begin
            FE_BIT       <= CMD_DATA;
            FE_BIT_VALID <= 1'b1;
          end
          if (fe_cnt == FE_LAST) begin
            state <= S_IDLE;
            if (match_q) begin
              SLOW_VALID <= 1'b1;
              SLOW_CMD   <= cmd_q;
              SLOW_ADDR  <= addr_q;
              SLOW_DATA  <= '0;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fei4_cmd_decoder.sv
// tb_fei4_cmd_decoder: directed vector table, hand sequences and a random stream checked against a stream parser model.
module tb_fei4_cmd_decoder;

  localparam int FE_BITS = 672;
  localparam int MAXN    = 8192;

  logic        CMD_CLK = 1'b0;
  logic        RESET;
  logic        CMD_DATA;
  logic [2:0]  CHIP_ID;
  logic        LV1, BCR, ECR, CAL, SLOW_VALID;
  logic [3:0]  SLOW_CMD;
  logic [5:0]  SLOW_ADDR;
  logic [15:0] SLOW_DATA;
  logic        FE_BIT, FE_BIT_VALID, RUN_MODE, BUSY, ERR;

  fei4_cmd_decoder #(.FE_BITS(FE_BITS)) dut (
    .CMD_CLK(CMD_CLK), .RESET(RESET), .CMD_DATA(CMD_DATA), .CHIP_ID(CHIP_ID),
    .LV1(LV1), .BCR(BCR), .ECR(ECR), .CAL(CAL),
    .SLOW_VALID(SLOW_VALID), .SLOW_CMD(SLOW_CMD), .SLOW_ADDR(SLOW_ADDR), .SLOW_DATA(SLOW_DATA),
    .FE_BIT(FE_BIT), .FE_BIT_VALID(FE_BIT_VALID), .RUN_MODE(RUN_MODE), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CMD_CLK = ~CMD_CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] bits;
    int          len;
    logic [5:0]  strobes;  // {LV1,BCR,ECR,CAL,SLOW_VALID,ERR} after the last bit
    logic [3:0]  cmd;
    logic [5:0]  addr;
    logic [15:0] data;
    logic        run;
  } vec_t;
  vec_t vt[$];

  // Stream and expected per-cycle outputs for the model-checked phase.
  int          sn;
  logic        sb     [MAXN];
  logic [35:0] exp_sn [MAXN];
  logic        e_lv1[MAXN], e_bcr[MAXN], e_ecr[MAXN], e_cal[MAXN], e_sv[MAXN];
  logic        e_feb[MAXN], e_fev[MAXN], e_busy[MAXN], e_err[MAXN], rm_set[MAXN], rm_val[MAXN];
  logic [3:0]  u_cmd[MAXN];
  logic [5:0]  u_addr[MAXN];
  logic [15:0] u_data[MAXN];
  logic [3:0]  m_cmd;
  logic [5:0]  m_addr;
  logic [15:0] m_data;
  logic        m_run;

  function automatic logic [35:0] snap();
    return {LV1, BCR, ECR, CAL, SLOW_VALID, SLOW_CMD, SLOW_ADDR, SLOW_DATA,
            FE_BIT, FE_BIT_VALID, RUN_MODE, BUSY, ERR};
  endfunction

  task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    CMD_DATA = b;
    @(posedge CMD_CLK);
    #1;
  endtask

  task automatic send_word(input logic [63:0] w, input int len);
    for (int i = len - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic do_reset();
    RESET    = 1'b1;
    CMD_DATA = 1'b0;
    repeat (3) @(posedge CMD_CLK);
    #1;
    RESET = 1'b0;
    m_cmd = '0; m_addr = '0; m_data = '0; m_run = 1'b0;
  endtask

  task automatic add(input logic [63:0] b, input int len, input logic [5:0] st, input logic [3:0] c,
                     input logic [5:0] a, input logic [15:0] d, input logic r);
    vec_t v;
    v.bits = b; v.len = len; v.strobes = st; v.cmd = c; v.addr = a; v.data = d; v.run = r;
    vt.push_back(v);
  endtask

  task automatic push(input logic [63:0] w, input int len);
    for (int j = len - 1; j >= 0; j--) begin
      sb[sn] = w[j];
      sn++;
    end
  endtask

  function automatic logic [15:0] get(input int i, input int w);
    logic [15:0] v;
    v = '0;
    for (int j = 0; j < w; j++) v = {v[14:0], (i + j < sn) ? sb[i + j] : 1'b0};
    return v;
  endfunction

  // Reference: parse the whole stream command by command, marking where each result must appear.
  task automatic build_expect();
    int i, s, e;
    logic [15:0] hdr, f2, w, d;
    logic [3:0] f3, f4;
    logic [5:0] f5;
    logic hit, known;
    for (int k = 0; k < MAXN; k++) begin
      e_lv1[k] = 0; e_bcr[k] = 0; e_ecr[k] = 0; e_cal[k] = 0; e_sv[k] = 0; e_feb[k] = 0;
      e_fev[k] = 0; e_busy[k] = 0; e_err[k] = 0; rm_set[k] = 0; rm_val[k] = 0;
      u_cmd[k] = 0; u_addr[k] = 0; u_data[k] = 0;
    end
    i = 0;
    while (i < sn) begin
      if (!sb[i]) begin
        i++;
        continue;
      end
      s = i;
      hdr = get(i, 5);
      e = i + 4;
      if (hdr[4:0] == 5'b11101) e_lv1[e] = 1;
      else if (hdr[4:0] == 5'b10110) begin
        f2 = get(i + 5, 4);
        e = i + 8;
        case (f2[3:0])
          4'b0001: e_bcr[e] = 1;
          4'b0010: e_ecr[e] = 1;
          4'b0100: e_cal[e] = 1;
          4'b1000: begin
            w = get(i + 9, 14);
            e = i + 22;
            f3 = w[13:10]; f4 = w[9:6]; f5 = w[5:0];
            hit = f4[3] || (f4[2:0] == CHIP_ID);
            known = f3 inside {4'd1, 4'd2, 4'd4, 4'd8, 4'd9, 4'd10};
            d = '0;
            if (f3 == 4'd2) begin
              d = get(i + 23, 16);
              e = i + 38;
            end else if (f3 == 4'd4) begin
              for (int j = 0; j < FE_BITS; j++) begin
                if (hit) begin
                  e_fev[i + 23 + j] = 1;
                  e_feb[i + 23 + j] = sb[i + 23 + j];
                end
              end
              e = i + 22 + FE_BITS;
            end
            if (!known) e_err[e] = 1;
            else if (hit) begin
              e_sv[e] = 1; u_cmd[e] = f3; u_addr[e] = f5; u_data[e] = d;
              if (f3 == 4'd10 && f5 == 6'b111000) begin rm_set[e] = 1; rm_val[e] = 1; end
              if (f3 == 4'd10 && f5 == 6'b000111) begin rm_set[e] = 1; rm_val[e] = 0; end
            end
          end
          default: e_err[e] = 1;
        endcase
      end else e_err[e] = 1;
      for (int k = s; k < e; k++) e_busy[k] = 1;
      i = e + 1;
    end
    for (int k = 0; k < sn; k++) begin
      if (e_sv[k]) begin m_cmd = u_cmd[k]; m_addr = u_addr[k]; m_data = u_data[k]; end
      if (rm_set[k]) m_run = rm_val[k];
      exp_sn[k] = {e_lv1[k], e_bcr[k], e_ecr[k], e_cal[k], e_sv[k], m_cmd, m_addr, m_data,
                   e_feb[k], e_fev[k], m_run, e_busy[k], e_err[k]};
    end
  endtask

  task automatic gen_stream(input int ncmd);
    int nfe;
    logic [4:0] h;
    logic [3:0] f2, f3, f4;
    logic [5:0] f5;
    sn = 0;
    nfe = 0;
    for (int c = 0; c < ncmd && sn < MAXN - 1000; c++) begin
      push(64'd0, $urandom_range(0, 2));
      case ($urandom_range(0, 10))
        0: push({59'd0, 5'b11101}, 5);
        1: push({55'd0, 5'b10110, 4'b0001}, 9);
        2: push({55'd0, 5'b10110, 4'b0010}, 9);
        3: push({55'd0, 5'b10110, 4'b0100}, 9);
        4: begin
          h = {1'b1, 4'($urandom)};
          if (h == 5'b11101 || h == 5'b10110) h = 5'b10000;
          push({59'd0, h}, 5);
        end
        5: begin
          f2 = 4'($urandom);
          if (f2 inside {4'd1, 4'd2, 4'd4, 4'd8}) f2 = 4'd0;
          push({55'd0, 5'b10110, f2}, 9);
        end
        default: begin
          case ($urandom_range(0, 7))
            0: f3 = 4'd1; 1: f3 = 4'd2; 2: f3 = 4'd4; 3: f3 = 4'd8;
            4: f3 = 4'd9; 5, 6: f3 = 4'd10; default: f3 = 4'($urandom);
          endcase
          if (f3 == 4'd4 && nfe >= 2) f3 = 4'd2;
          f4 = $urandom_range(0, 1) ? {1'b0, CHIP_ID} : 4'($urandom);
          case ($urandom_range(0, 3))
            0: f5 = 6'b111000; 1: f5 = 6'b000111; default: f5 = 6'($urandom);
          endcase
          push({41'd0, 5'b10110, 4'b1000, f3, f4, f5}, 23);
          if (f3 == 4'd2) push(64'($urandom), 16);
          if (f3 == 4'd4) begin
            nfe++;
            for (int j = 0; j < FE_BITS; j++) push(64'($urandom_range(0, 1)), 1);
          end
        end
      endcase
    end
    push(64'd0, 3);
  endtask

  task automatic run_random(input int ncmd);
    gen_stream(ncmd);
    build_expect();
    for (int k = 0; k < sn; k++) begin
      send_bit(sb[k]);
      check("rand", k, 64'(snap()), 64'(exp_sn[k]));
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] lv1v, busyv;
    logic       other;
    int         fev_n, feb_bad, sv_n, vidx;
    logic [4:0] badhdr;

    CHIP_ID  = 3'd3;
    CMD_DATA = 1'b0;
    do_reset();
    check("reset", 0, 64'(snap()), 64'd0);

    // LV1 from IDLE: strobe after the 5th bit, BUSY for 4 cycles.
    lv1v = '0; busyv = '0; other = 1'b0;
    for (int k = 0; k < 8; k++) begin
      send_bit(k < 3 || k == 4);
      lv1v[k] = LV1; busyv[k] = BUSY;
      other = other | BCR | ECR | CAL | SLOW_VALID | ERR | FE_BIT_VALID;
    end
    check("lv1_pulse", 0, 64'(lv1v), 64'h10);
    check("lv1_busy", 0, 64'(busyv), 64'h0F);
    check("lv1_other", 0, 64'(other), 64'd0);

    // Directed table, applied back to back.
    add(64'b11101, 5, 6'b100000, 4'h0, 6'd0, 16'h0, 1'b0);
    add({55'd0, 5'b10110, 4'b0001}, 9, 6'b010000, 4'h0, 6'd0, 16'h0, 1'b0);
    add(64'(16'hB100) >> 7, 9, 6'b001000, 4'h0, 6'd0, 16'h0, 1'b0);
    add({55'd0, 5'b10110, 4'b0100}, 9, 6'b000100, 4'h0, 6'd0, 16'h0, 1'b0);
    add({25'd0, 5'b10110, 4'b1000, 4'b0010, 4'b1000, 6'd27, 16'h8000}, 39, 6'b000010, 4'h2, 6'd27, 16'h8000, 1'b0);
    add({41'd0, 5'b10110, 4'b1000, 4'b1010, 4'b1000, 6'b111000}, 23, 6'b000010, 4'hA, 6'd56, 16'h0, 1'b1);
    add({25'd0, 5'b10110, 4'b1000, 4'b0010, 4'b0101, 6'd1, 16'h1234}, 39, 6'b000000, 4'hA, 6'd56, 16'h0, 1'b1);
    add(64'b11101, 5, 6'b100000, 4'hA, 6'd56, 16'h0, 1'b1);
    add({41'd0, 5'b10110, 4'b1000, 4'b1010, 4'b0011, 6'b000111}, 23, 6'b000010, 4'hA, 6'd7, 16'h0, 1'b0);
    add({41'd0, 5'b10110, 4'b1000, 4'b1010, 4'b1000, 6'b010101}, 23, 6'b000010, 4'hA, 6'd21, 16'h0, 1'b0);
    add({41'd0, 5'b10110, 4'b1000, 4'b0001, 4'b0011, 6'd5}, 23, 6'b000010, 4'h1, 6'd5, 16'h0, 1'b0);
    add({41'd0, 5'b10110, 4'b1000, 4'b1001, 4'b0011, 6'd10}, 23, 6'b000010, 4'h9, 6'd10, 16'h0, 1'b0);
    add({41'd0, 5'b10110, 4'b1000, 4'b0011, 4'b1000, 6'd9}, 23, 6'b000001, 4'h9, 6'd10, 16'h0, 1'b0);
    add(64'b11000, 5, 6'b000001, 4'h9, 6'd10, 16'h0, 1'b0);
    add({55'd0, 5'b10110, 4'b0011}, 9, 6'b000001, 4'h9, 6'd10, 16'h0, 1'b0);
    add({41'd0, 5'b10110, 4'b1000, 4'b1000, 4'b0110, 6'd0}, 23, 6'b000000, 4'h9, 6'd10, 16'h0, 1'b0);
    add({41'd0, 5'b10110, 4'b1000, 4'b1010, 4'b0010, 6'b111000}, 23, 6'b000000, 4'h9, 6'd10, 16'h0, 1'b0);
    add({41'd0, 5'b10110, 4'b1000, 4'b1010, 4'b0011, 6'b111000}, 23, 6'b000010, 4'hA, 6'd56, 16'h0, 1'b1);
    add({25'd0, 5'b10110, 4'b1000, 4'b0010, 4'b0011, 6'd63, 16'hFFFF}, 39, 6'b000010, 4'h2, 6'd63, 16'hFFFF, 1'b1);
    add({41'd0, 5'b10110, 4'b1000, 4'b1000, 4'b1111, 6'd0}, 23, 6'b000010, 4'h8, 6'd0, 16'h0, 1'b1);
    vidx = 0;
    foreach (vt[i]) begin
      send_word(vt[i].bits, vt[i].len);
      check("vec", vidx,
            64'({LV1, BCR, ECR, CAL, SLOW_VALID, ERR, SLOW_CMD, SLOW_ADDR, SLOW_DATA, RUN_MODE, BUSY}),
            64'({vt[i].strobes, vt[i].cmd, vt[i].addr, vt[i].data, vt[i].run, 1'b0}));
      vidx++;
    end

    // WrFE broadcast with alternating payload starting at 1.
    send_word({41'd0, 5'b10110, 4'b1000, 4'b0100, 4'b1000, 6'd0}, 23);
    fev_n = 0; feb_bad = 0; sv_n = 0;
    for (int j = 0; j < FE_BITS + 4; j++) begin
      send_bit(j < FE_BITS ? ((j % 2) == 0) : 1'b0);
      if (FE_BIT_VALID) begin
        if (FE_BIT !== ((fev_n % 2) == 0)) feb_bad++;
        fev_n++;
      end
      if (SLOW_VALID) begin
        sv_n++;
        check("wrfe_sv_pos", j, 64'(j), 64'(FE_BITS - 1));
      end
    end
    check("wrfe_valid_cnt", 0, 64'(fev_n), 64'(FE_BITS));
    check("wrfe_bit_errs", 0, 64'(feb_bad), 64'd0);
    check("wrfe_sv_cnt", 0, 64'(sv_n), 64'd1);
    check("wrfe_cmd", 0, 64'(SLOW_CMD), 64'h4);

    // Reset in the middle of a WrReg data field aborts it silently.
    send_word({41'd0, 5'b10110, 4'b1000, 4'b0010, 4'b1000, 6'd3}, 23);
    sv_n = 0;
    for (int j = 0; j < 8; j++) begin
      send_bit(1'b1);
      sv_n += SLOW_VALID;
    end
    RESET = 1'b1;
    send_bit(1'b1);
    sv_n += SLOW_VALID;
    check("midrst_zero", 0, 64'(snap()), 64'd0);
    RESET = 1'b0;
    send_word({55'd0, 5'b10110, 4'b0010}, 9);
    sv_n += SLOW_VALID;
    check("midrst_no_sv", 0, 64'(sv_n), 64'd0);
    check("midrst_ecr", 0, 64'(snap()), 64'({5'b00100, 31'd0}));

    // A second illegal header variant, then the random stream phases.
    badhdr = 5'b10111;
    send_word(64'(badhdr), 5);
    check("badhdr_err", 0, 64'({ERR, BUSY}), 64'b10);

    do_reset();
    run_random(40);
    CHIP_ID = 3'($urandom);
    do_reset();
    run_random(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
